// File: rtl/vscale_htif_host_pkg.sv
// vscale_htif_host_pkg: shared CSR/HTIF constants and host FSM encodings.
package vscale_htif_host_pkg;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int HTIF_PCR_WIDTH = 64;
    localparam int IDX_W = 4;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_ADDR_TO_HOST = 12'h780;
    localparam logic [HTIF_PCR_WIDTH-1:0] TOHOST_PASS = 64'd1;
    typedef enum logic [2:0] {
        ST_WAIT    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_RESP = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_HALT    = 3'd6
    } host_state_e;
endpackage

// File: rtl/vscale_rr_next_idx.sv
// vscale_rr_next_idx: next index after cur (wrapping, cur itself last) whose done bit is clear.
module vscale_rr_next_idx import vscale_htif_host_pkg::*; #(
    parameter int N_CORES = 1
) (
    input  logic [IDX_W-1:0]   cur,
    input  logic [N_CORES-1:0] done_mask,
    output logic [IDX_W-1:0]   nxt,
    output logic               all_done
);
    logic [15:0] mask16;
    assign mask16 = 16'(done_mask);
    assign all_done = &done_mask;
    // Scan from the farthest offset down so the nearest unfinished index wins.
    always_comb begin
        nxt = cur;
        for (int k = N_CORES; k >= 1; k--) begin
            if (!mask16[IDX_W'((int'(cur) + k) % N_CORES)]) nxt = IDX_W'((int'(cur) + k) % N_CORES);
        end
    end
endmodule

// File: rtl/vscale_htif_host.sv
// vscale_htif_host: round-robin tohost poller/acknowledger with pass/fail decode and global timeout.
module vscale_htif_host import vscale_htif_host_pkg::*; #(
    parameter int          N_CORES        = 1,
    parameter int          POLL_INTERVAL  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                                clk,
    input  logic                                reset,
    output logic [N_CORES-1:0]                  htif_pcr_req_valid,
    input  logic [N_CORES-1:0]                  htif_pcr_req_ready,
    output logic                                htif_pcr_req_rw,
    output logic [CSR_ADDR_WIDTH-1:0]           htif_pcr_req_addr,
    output logic [HTIF_PCR_WIDTH-1:0]           htif_pcr_req_data,
    input  logic [N_CORES-1:0]                  htif_pcr_resp_valid,
    output logic [N_CORES-1:0]                  htif_pcr_resp_ready,
    input  logic [N_CORES*HTIF_PCR_WIDTH-1:0]   htif_pcr_resp_data,
    output logic [N_CORES-1:0]                  core_done,
    output logic                                done,
    output logic                                pass,
    output logic                                timeout,
    output logic [3:0]                          fail_core,
    output logic [HTIF_PCR_WIDTH-1:0]           fail_code
);
    host_state_e state, state_n;
    logic [31:0] wait_cnt, cyc;
    logic [IDX_W-1:0] sel, nxt_sel;
    logic [HTIF_PCR_WIDTH-1:0] val, rdata;
    logic [HTIF_PCR_WIDTH-1:0] resp_words [16];
    logic [15:0] req_ready16, resp_valid16;
    logic [N_CORES-1:0] sel_mask;
    logic any_fail, tmo_halt, all_done, req_fire, resp_fire, tmo_hit;

    for (genvar g = 0; g < 16; g++) begin : g_word
        if (g < N_CORES) begin : g_in
            assign resp_words[g] = htif_pcr_resp_data[g*HTIF_PCR_WIDTH +: HTIF_PCR_WIDTH];
        end else begin : g_pad
            assign resp_words[g] = '0;
        end
    end

    assign sel_mask     = N_CORES'(1) << sel;
    assign req_ready16  = 16'(htif_pcr_req_ready);
    assign resp_valid16 = 16'(htif_pcr_resp_valid);
    assign req_fire     = req_ready16[sel];
    assign resp_fire    = resp_valid16[sel];
    assign rdata        = resp_words[sel];
    assign tmo_hit      = cyc >= TIMEOUT_CYCLES;

    assign htif_pcr_req_valid  = (state == ST_RD_REQ || state == ST_WR_REQ) ? sel_mask : '0;
    assign htif_pcr_resp_ready = (state == ST_RD_RESP || state == ST_WR_RESP) ? sel_mask : '0;
    assign htif_pcr_req_rw     = state == ST_WR_REQ;
    assign htif_pcr_req_addr   = CSR_ADDR_TO_HOST;
    assign htif_pcr_req_data   = '0;

    vscale_rr_next_idx #(.N_CORES(N_CORES)) u_next (
        .cur       (sel),
        .done_mask (core_done),
        .nxt       (nxt_sel),
        .all_done  (all_done)
    );

    // Timeout only exits at points where no request is outstanding.
    always_comb begin
        state_n = state;
        case (state)
            ST_WAIT:    state_n = tmo_hit ? ST_HALT : (wait_cnt == 32'(POLL_INTERVAL - 1)) ? ST_RD_REQ : ST_WAIT;
            ST_RD_REQ:  state_n = req_fire ? ST_RD_RESP : ST_RD_REQ;
            ST_RD_RESP: state_n = !resp_fire ? ST_RD_RESP : tmo_hit ? ST_HALT : (rdata != '0) ? ST_WR_REQ : ST_ADVANCE;
            ST_WR_REQ:  state_n = req_fire ? ST_WR_RESP : ST_WR_REQ;
            ST_WR_RESP: state_n = resp_fire ? ST_ADVANCE : ST_WR_RESP;
            ST_ADVANCE: state_n = (all_done || tmo_hit) ? ST_HALT : ST_WAIT;
            default:    state_n = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_WAIT;
            wait_cnt  <= '0;
            cyc       <= '0;
            sel       <= '0;
            val       <= '0;
            core_done <= '0;
            any_fail  <= 1'b0;
            tmo_halt  <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_core <= '0;
            fail_code <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= (state == ST_WAIT && state_n == ST_WAIT) ? wait_cnt + 32'd1 : '0;
            if (state != ST_HALT) cyc <= cyc + 32'd1;
            if (state == ST_RD_RESP && resp_fire) val <= rdata;
            if (state == ST_WR_RESP && resp_fire) begin
                core_done <= core_done | sel_mask;
                if (val != TOHOST_PASS && !any_fail) begin
                    any_fail  <= 1'b1;
                    fail_core <= sel;
                    fail_code <= val >> 1;
                end
            end
            if (state == ST_ADVANCE) sel <= nxt_sel;
            // A final completion coinciding with the limit still counts as a clean finish.
            if (state_n == ST_HALT && state != ST_HALT) tmo_halt <= ~all_done;
            done    <= state == ST_HALT;
            timeout <= state == ST_HALT && tmo_halt;
            pass    <= state == ST_HALT && !tmo_halt && !any_fail;
        end
    end
endmodule

// File: tb/tb_vscale_htif_host.sv
// tb_vscale_htif_host: randomized per-core tohost responders checked against a poll-order/pass-fail model.
module tb_vscale_htif_host;
    import vscale_htif_host_pkg::*;
    localparam int N = 4;
    localparam int W = HTIF_PCR_WIDTH;
    localparam int PI = 3;
    localparam int TO = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [N-1:0] req_valid, resp_ready, core_done;
    logic [N-1:0] req_ready = '0;
    logic [N-1:0] resp_valid = '0;
    logic [N*W-1:0] resp_data = '0;
    logic req_rw, done, pass, timeout;
    logic [CSR_ADDR_WIDTH-1:0] req_addr;
    logic [W-1:0] req_data, fail_code;
    logic [3:0] fail_core;

    always #5 clk = ~clk;

    vscale_htif_host #(.N_CORES(N), .POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .htif_pcr_req_valid  (req_valid),
        .htif_pcr_req_ready  (req_ready),
        .htif_pcr_req_rw     (req_rw),
        .htif_pcr_req_addr   (req_addr),
        .htif_pcr_req_data   (req_data),
        .htif_pcr_resp_valid (resp_valid),
        .htif_pcr_resp_ready (resp_ready),
        .htif_pcr_resp_data  (resp_data),
        .core_done           (core_done),
        .done                (done),
        .pass                (pass),
        .timeout             (timeout),
        .fail_core           (fail_core),
        .fail_code           (fail_code)
    );

    int tests = 0;
    int fails = 0;
    int cycle = 0;
    // Scenario configuration, written only by the stimulus block.
    int zeros [N];
    logic [W-1:0] fin [N];
    int fix_dly = -1;
    int stall_until = 0;
    bit wr_block = 1'b0;
    // Responder state, written only by the responder block.
    logic [W-1:0] tv [N];
    logic [W-1:0] rdata [N];
    int reads [N];
    int writes [N];
    int dly [N];
    bit pend [N];
    int polls [$];
    logic [N-1:0] prev_v = '0;
    logic prev_rw = 1'b0;
    bit prev_acc = 1'b0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Each core: reads return 0 for the first zeros[i] polls, then its tohost value until written.
    always @(negedge clk) begin
        if (reset) begin
            req_ready = '0;
            resp_valid = '0;
            for (int i = 0; i < N; i++) begin
                pend[i] = 1'b0;
                tv[i] = fin[i];
                reads[i] = 0;
                writes[i] = 0;
            end
            polls.delete();
            prev_v = '0;
            prev_acc = 1'b0;
        end else begin
            if (req_valid != '0) begin
                check("req_onehot", 64'($onehot(req_valid)), 1);
                check("req_addr", 64'(req_addr), 64'(CSR_ADDR_TO_HOST));
                if (prev_v != '0 && !prev_acc) begin
                    check("req_valid_stable", 64'(req_valid), 64'(prev_v));
                    check("req_rw_stable", 64'(req_rw), 64'(prev_rw));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (pend[i] && dly[i] > 0) begin
                    dly[i]--;
                    resp_valid[i] = 1'b0;
                end else if (pend[i]) begin
                    resp_valid[i] = 1'b1;
                    resp_data[i*W +: W] = rdata[i];
                end else begin
                    resp_valid[i] = ($urandom_range(3) == 0);
                    resp_data[i*W +: W] = {$urandom, $urandom};
                end
                req_ready[i] = !pend[i] && cycle >= stall_until && !(wr_block && req_rw) && ($urandom_range(3) != 0);
            end
            for (int i = 0; i < N; i++) begin
                if (resp_valid[i] && resp_ready[i]) begin
                    check($sformatf("resp_owned%0d", i), 64'(pend[i]), 1);
                    pend[i] = 1'b0;
                end
                if (req_valid[i] && req_ready[i]) begin
                    if (req_rw) begin
                        check($sformatf("wr_data%0d", i), req_data, 0);
                        writes[i]++;
                        tv[i] = '0;
                        rdata[i] = {$urandom, $urandom};
                    end else begin
                        polls.push_back(i);
                        rdata[i] = (reads[i] < zeros[i]) ? '0 : tv[i];
                        reads[i]++;
                    end
                    pend[i] = 1'b1;
                    dly[i] = (fix_dly >= 0) ? fix_dly : int'($urandom_range(2));
                end
            end
            prev_v = req_valid;
            prev_rw = req_rw;
            prev_acc = |(req_valid & req_ready);
        end
    end

    task automatic start_scenario();
        @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < TO + 300) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"}, 64'(req_valid), 0);
        check({tag, "_resp_ready"}, 64'(resp_ready), 0);
        check({tag, "_core_done"}, 64'(core_done), 0);
        check({tag, "_done"}, 64'(done), 0);
        check({tag, "_pass"}, 64'(pass), 0);
        check({tag, "_timeout"}, 64'(timeout), 0);
        check({tag, "_fail_core"}, 64'(fail_core), 0);
        check({tag, "_fail_code"}, fail_code, 0);
    endtask

    // Reference: walk the round-robin poll list over unfinished cores.
    task automatic finish_scenario(input string tag);
        int cyc;
        int eq [$];
        int er [N];
        bit ed [N];
        int idx = 0;
        int ndone = 0;
        int ff = -1;
        logic [W-1:0] ecode = '0;
        wait_done(cyc);
        check({tag, "_done"}, 64'(done), 1);
        for (int i = 0; i < N; i++) begin
            er[i] = 0;
            ed[i] = 1'b0;
        end
        while (ndone < N && eq.size() < 1000) begin
            eq.push_back(idx);
            if (er[idx] >= zeros[idx]) begin
                ed[idx] = 1'b1;
                ndone++;
                if (fin[idx] != 1 && ff < 0) begin
                    ff = idx;
                    ecode = fin[idx] >> 1;
                end
            end
            er[idx]++;
            for (int k = 1; k <= N; k++) begin
                if (!ed[(idx + k) % N]) begin
                    idx = (idx + k) % N;
                    break;
                end
            end
        end
        check({tag, "_poll_count"}, 64'(polls.size()), 64'(eq.size()));
        for (int i = 0; i < eq.size() && i < polls.size(); i++)
            check($sformatf("%s_poll%0d", tag, i), 64'(polls[i]), 64'(eq[i]));
        for (int i = 0; i < N; i++)
            check($sformatf("%s_writes%0d", tag, i), 64'(writes[i]), 1);
        check({tag, "_core_done"}, 64'(core_done), 64'({N{1'b1}}));
        check({tag, "_timeout"}, 64'(timeout), 0);
        check({tag, "_pass"}, 64'(pass), 64'(ff < 0));
        check({tag, "_fail_core"}, 64'(fail_core), 64'((ff < 0) ? 0 : ff));
        check({tag, "_fail_code"}, fail_code, ecode);
        check({tag, "_idle"}, 64'(req_valid), 0);
    endtask

    initial begin
        int c;
        logic [W-1:0] v;
        for (int i = 0; i < N; i++) begin
            zeros[i] = 0;
            fin[i] = 64'd1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");

        zeros = '{1, 3, 0, 2};
        start_scenario();
        finish_scenario("rr_order");

        zeros = '{5, 0, 0, 0};
        start_scenario();
        finish_scenario("five_zeros");

        zeros = '{0, 0, 0, 0};
        fin = '{64'd1, 64'd7, 64'd1, 64'd1};
        start_scenario();
        finish_scenario("fail7");

        zeros = '{1, 0, 0, 0};
        fin = '{64'd6, 64'd1, 64'd9, 64'd1};
        start_scenario();
        finish_scenario("multi_fail");

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < N; i++) begin
                zeros[i] = int'($urandom_range(3));
                v = {$urandom, $urandom};
                fin[i] = ($urandom_range(2) == 0) ? ((v == '0) ? 64'd2 : v) : 64'd1;
            end
            start_scenario();
            finish_scenario($sformatf("rand%0d", r));
        end

        zeros = '{2, 0, 1, 0};
        fin = '{64'd1, 64'd1, 64'd1, 64'd1};
        fix_dly = 7;
        start_scenario();
        stall_until = cycle + 12;
        finish_scenario("stall");
        fix_dly = -1;

        zeros = '{100000, 100000, 100000, 100000};
        start_scenario();
        wait_done(c);
        check("tmo_done", 64'(done), 1);
        check("tmo_flag", 64'(timeout), 1);
        check("tmo_pass", 64'(pass), 0);
        check("tmo_core_done", 64'(core_done), 0);
        check("tmo_window", 64'(c >= TO && c <= TO + 60), 1);
        check("tmo_req_idle", 64'(req_valid), 0);
        check("tmo_resp_idle", 64'(resp_ready), 0);

        zeros = '{0, 0, 0, 0};
        wr_block = 1'b1;
        start_scenario();
        c = 0;
        while (!(req_valid != '0 && req_rw) && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("wr_req_reached", 64'(req_valid != '0 && req_rw), 1);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset_values("mid_reset");
        check("mid_reset_rw", 64'(req_rw), 0);
        wr_block = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        finish_scenario("after_reset");
        check("after_reset_first_poll", 64'((polls.size() > 0) ? polls[0] : -1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
